rename_stage: RTL and testbench

- Register-rename stage directly downstream of the decoder.
- Consumes decoded architectural operands (Ra, Rb, Rw) and op-type valids (add/mul).
- Maps them through a register alias table (RAT) onto physical registers, allocating a new destination tag from a free list.
- Emits a registered, renamed micro-op to dispatch; commit returns retired physical tags to the free list.

---
 rtl/rename_pkg.sv | 32 +++
 rtl/rename_free_list.sv | 61 ++++++
 rtl/rename_stage.sv | 123 ++++++++++++
 tb/tb_rename_stage.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/rename_pkg.sv
// Shared types and sizing for the register-rename stage.
package rename_pkg;

  localparam int AREG_NUM = 8;
  localparam int PREG_NUM = 16;
  localparam int AREG_W   = 3;
  localparam int PREG_W   = $clog2(PREG_NUM);
  localparam int FL_DEPTH = PREG_NUM - AREG_NUM;
  localparam int FL_PTR_W = $clog2(FL_DEPTH);
  localparam int FL_CNT_W = $clog2(FL_DEPTH + 1);

  typedef logic [AREG_W-1:0]   areg_t;
  typedef logic [PREG_W-1:0]   preg_t;
  typedef logic [FL_PTR_W-1:0] fl_ptr_t;
  typedef logic [FL_CNT_W-1:0] fl_cnt_t;

  typedef struct packed {
    preg_t pa;
    preg_t pb;
    preg_t pw;
    preg_t pw_old;
    logic  is_add;
    logic  is_mul;
  } renamed_uop_t;

  // Explicit wrap so a non-power-of-two depth still works.
  function automatic fl_ptr_t fl_ptr_inc(input fl_ptr_t ptr);
    if (ptr == fl_ptr_t'(FL_DEPTH - 1)) return '0;
    return ptr + fl_ptr_t'(1);
  endfunction

endpackage

// File: rtl/rename_free_list.sv
// Circular FIFO of free physical tags; resets holding tags AREG_NUM..PREG_NUM-1 in order.
module free_list
  import rename_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    pop,
  input  logic    push,
  input  preg_t   push_tag,
  output preg_t   head_tag,
  output fl_cnt_t count,
  output logic    empty,
  output logic    full
);

  preg_t   mem_reg [FL_DEPTH];
  fl_ptr_t head_reg;
  fl_ptr_t tail_reg;
  fl_cnt_t count_reg;

  logic do_pop;
  logic do_push;

  assign empty    = (count_reg == '0);
  assign full     = (count_reg == fl_cnt_t'(FL_DEPTH));
  assign count    = count_reg;
  assign head_tag = mem_reg[head_reg];
  assign do_pop   = pop && !empty;
  // A push into a full list is dropped so the count saturates.
  assign do_push  = push && !full;

  genvar gi;
  generate
    for (gi = 0; gi < FL_DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          mem_reg[gi] <= preg_t'(AREG_NUM + gi);
        end else if (do_push && (tail_reg == fl_ptr_t'(gi))) begin
          mem_reg[gi] <= push_tag;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= fl_cnt_t'(FL_DEPTH);
    end else begin
      if (do_pop)  head_reg <= fl_ptr_inc(head_reg);
      if (do_push) tail_reg <= fl_ptr_inc(tail_reg);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + fl_cnt_t'(1);
        2'b01:   count_reg <= count_reg - fl_cnt_t'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/rename_stage.sv
// Rename stage: RAT lookup, free-list allocation, registered micro-op to dispatch.
// Optional RENAME_STALL_STATS_EN adds saturating stall/allocation counters.
module rename_stage
  import rename_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  areg_t Ra,
  input  areg_t Rb,
  input  areg_t Rw,
  input  logic  valid_add,
  input  logic  valid_mul,
  output logic  rename_ready,
  output preg_t Pa,
  output preg_t Pb,
  output preg_t Pw,
  output preg_t Pw_old,
  output logic  out_add,
  output logic  out_mul,
  input  logic  dispatch_ready,
  input  logic  commit_valid,
  input  preg_t commit_preg
`ifdef RENAME_STALL_STATS_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] alloc_count
`endif
);

  preg_t        rat_reg [AREG_NUM];
  renamed_uop_t uop_reg;
  renamed_uop_t uop_next;

  preg_t   fl_head;
  fl_cnt_t fl_count;
  logic    fl_empty;
  logic    fl_full;

  logic in_valid;
  logic out_valid;
  logic accept;

  assign in_valid     = valid_add | valid_mul;
  assign out_valid    = uop_reg.is_add | uop_reg.is_mul;
  assign rename_ready = !fl_empty && (!out_valid || dispatch_ready);
  assign accept       = in_valid && rename_ready;

  free_list u_free_list (
    .clk      (clk),
    .rst      (rst),
    .pop      (accept),
    .push     (commit_valid),
    .push_tag (commit_preg),
    .head_tag (fl_head),
    .count    (fl_count),
    .empty    (fl_empty),
    .full     (fl_full)
  );

  genvar gi;
  generate
    for (gi = 0; gi < AREG_NUM; gi++) begin : g_rat
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          rat_reg[gi] <= preg_t'(gi);
        end else if (accept && (Rw == areg_t'(gi))) begin
          rat_reg[gi] <= fl_head;
        end
      end
    end
  endgenerate

  // Sources read the pre-update RAT, so Ra==Rw sees the previous mapping.
  always_comb begin
    uop_next = uop_reg;
    if (accept) begin
      uop_next.pa     = rat_reg[Ra];
      uop_next.pb     = rat_reg[Rb];
      uop_next.pw     = fl_head;
      uop_next.pw_old = rat_reg[Rw];
      uop_next.is_add = valid_add && !valid_mul;
      uop_next.is_mul = valid_mul;
    end else if (dispatch_ready) begin
      uop_next.is_add = 1'b0;
      uop_next.is_mul = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) uop_reg <= '0;
    else     uop_reg <= uop_next;
  end

  assign Pa      = uop_reg.pa;
  assign Pb      = uop_reg.pb;
  assign Pw      = uop_reg.pw;
  assign Pw_old  = uop_reg.pw_old;
  assign out_add = uop_reg.is_add;
  assign out_mul = uop_reg.is_mul;

`ifdef RENAME_STALL_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= '0;
      alloc_count  <= '0;
    end else begin
      if (in_valid && !rename_ready && (stall_cycles != 32'hFFFF_FFFF))
        stall_cycles <= stall_cycles + 32'd1;
      if (accept && (alloc_count != 32'hFFFF_FFFF))
        alloc_count <= alloc_count + 32'd1;
    end
  end
`endif

`ifndef SYNTHESIS
  a_single_op: assert property (@(posedge clk) disable iff (rst) !(valid_add && valid_mul));
  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(commit_valid && fl_full));
`endif

  logic unused_count;
  assign unused_count = ^fl_count;

endmodule

// File: tb/tb_rename_stage.sv
// Directed table-driven bench for rename_stage plus free-list reference-model sequence.
module tb_rename_stage;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] Ra = '0, Rb = '0, Rw = '0;
  logic       valid_add = 1'b0, valid_mul = 1'b0;
  logic       rename_ready;
  logic [3:0] Pa, Pb, Pw, Pw_old;
  logic       out_add, out_mul;
  logic       dispatch_ready = 1'b1;
  logic       commit_valid = 1'b0;
  logic [3:0] commit_preg = '0;
`ifdef RENAME_STALL_STATS_EN
  logic [31:0] stall_cycles, alloc_count;
`endif

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  rename_stage dut (
    .clk            (clk),
    .rst            (rst),
    .Ra             (Ra),
    .Rb             (Rb),
    .Rw             (Rw),
    .valid_add      (valid_add),
    .valid_mul      (valid_mul),
    .rename_ready   (rename_ready),
    .Pa             (Pa),
    .Pb             (Pb),
    .Pw             (Pw),
    .Pw_old         (Pw_old),
    .out_add        (out_add),
    .out_mul        (out_mul),
    .dispatch_ready (dispatch_ready),
    .commit_valid   (commit_valid),
    .commit_preg    (commit_preg)
`ifdef RENAME_STALL_STATS_EN
    ,
    .stall_cycles   (stall_cycles),
    .alloc_count    (alloc_count)
`endif
  );

  typedef struct {
    logic       va, vm;
    logic [2:0] ra, rb, rw;
    logic       dr, cv;
    logic [3:0] cp;
    logic       exp_ready;
    logic       exp_add, exp_mul;
    logic       chk_tags;
    logic [3:0] pa, pb, pw, pwo;
  } vec_t;

  vec_t vecs [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive at negedge, sample ready before the edge, return #1 after the posedge.
  task automatic step(input logic va, input logic vm, input logic [2:0] ra_i, input logic [2:0] rb_i,
                      input logic [2:0] rw_i, input logic dr, input logic cv, input logic [3:0] cp,
                      output logic rdy);
    @(negedge clk);
    valid_add = va; valid_mul = vm;
    Ra = ra_i; Rb = rb_i; Rw = rw_i;
    dispatch_ready = dr; commit_valid = cv; commit_preg = cp;
    #1 rdy = rename_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string name, input logic ea, input logic em, input logic tags,
                         input logic [3:0] pa, input logic [3:0] pb, input logic [3:0] pw,
                         input logic [3:0] pwo);
    chk({name, ".out_add"}, 32'(out_add), 32'(ea));
    chk({name, ".out_mul"}, 32'(out_mul), 32'(em));
    if (tags) begin
      chk({name, ".Pa"}, 32'(Pa), 32'(pa));
      chk({name, ".Pb"}, 32'(Pb), 32'(pb));
      chk({name, ".Pw"}, 32'(Pw), 32'(pw));
      chk({name, ".Pw_old"}, 32'(Pw_old), 32'(pwo));
    end
  endtask

  logic       rdy;
  logic [3:0] rat_m [8];
  logic [3:0] fl_q [$];

  initial begin
    //          va vm ra rb rw dr cv cp  rdy add mul tags pa  pb  pw  pwo
    vecs[0]  = '{1, 0, 1, 2, 3, 1, 0, 0,  1, 1, 0, 1,  1,  2,  8,  3};
    vecs[1]  = '{0, 1, 3, 3, 3, 1, 0, 0,  1, 0, 1, 1,  8,  8,  9,  8};
    vecs[2]  = '{1, 0, 0, 7, 5, 1, 0, 0,  1, 1, 0, 1,  0,  7, 10,  5};
    vecs[3]  = '{0, 0, 0, 0, 0, 1, 0, 0,  1, 0, 0, 0,  0,  0,  0,  0};
    vecs[4]  = '{0, 1, 5, 3, 0, 1, 0, 0,  1, 0, 1, 1, 10,  9, 11,  0};
    vecs[5]  = '{1, 0, 6, 6, 6, 1, 0, 0,  1, 1, 0, 1,  6,  6, 12,  6};
    vecs[6]  = '{1, 0, 1, 1, 1, 1, 0, 0,  1, 1, 0, 1,  1,  1, 13,  1};
    vecs[7]  = '{1, 0, 2, 1, 2, 1, 0, 0,  1, 1, 0, 1,  2, 13, 14,  2};
    vecs[8]  = '{0, 1, 4, 2, 7, 1, 0, 0,  1, 0, 1, 1,  4, 14, 15,  7};
    vecs[9]  = '{1, 0, 0, 0, 0, 1, 1, 3,  0, 0, 0, 0,  0,  0,  0,  0};
    vecs[10] = '{1, 0, 0, 0, 0, 1, 0, 0,  1, 1, 0, 1, 11, 11,  3, 11};
    vecs[11] = '{0, 0, 0, 0, 0, 1, 1, 8,  0, 0, 0, 0,  0,  0,  0,  0};
    vecs[12] = '{0, 0, 0, 0, 0, 1, 1, 10, 1, 0, 0, 0,  0,  0,  0,  0};

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_out("reset", 1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 4'd0, 4'd0);
    chk("reset.ready", 32'(rename_ready), 32'd1);
    rst = 1'b0;
    $display("reset released");

    // Table: basic renames, RAT forwarding, empty list with commit
    for (int i = 0; i < 13; i++) begin
      step(vecs[i].va, vecs[i].vm, vecs[i].ra, vecs[i].rb, vecs[i].rw,
           vecs[i].dr, vecs[i].cv, vecs[i].cp, rdy);
      chk($sformatf("vec%0d.ready", i), 32'(rdy), 32'(vecs[i].exp_ready));
      chk_out($sformatf("vec%0d", i), vecs[i].exp_add, vecs[i].exp_mul, vecs[i].chk_tags,
              vecs[i].pa, vecs[i].pb, vecs[i].pw, vecs[i].pwo);
      $display("vec %0d: ready=%0b add=%0b mul=%0b Pa=%0d Pb=%0d Pw=%0d Pw_old=%0d",
               i, rdy, out_add, out_mul, Pa, Pb, Pw, Pw_old);
    end

    // Downstream stall holds the output and blocks allocation
    step(1, 0, 3, 0, 4, 1, 0, 0, rdy);
    chk("stall.pre.ready", 32'(rdy), 32'd1);
    chk_out("stall.pre", 1'b1, 1'b0, 1'b1, 4'd9, 4'd3, 4'd8, 4'd4);
    $display("stall pre: Pw=%0d", Pw);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 4, 4, 5, 0, 0, 0, rdy);
      chk($sformatf("stall%0d.ready", i), 32'(rdy), 32'd0);
      chk_out($sformatf("stall%0d", i), 1'b1, 1'b0, 1'b1, 4'd9, 4'd3, 4'd8, 4'd4);
      $display("stall cycle %0d: ready=%0b Pw=%0d", i, rdy, Pw);
    end
    step(0, 1, 4, 4, 5, 1, 0, 0, rdy);
    chk("stall.rel.ready", 32'(rdy), 32'd1);
    chk_out("stall.rel", 1'b0, 1'b1, 1'b1, 4'd8, 4'd8, 4'd10, 4'd10);
    $display("stall release: Pw=%0d Pw_old=%0d", Pw, Pw_old);

    // Fresh reset, five allocations, then asynchronous reset mid-stream
    @(negedge clk); rst = 1'b1; valid_add = 1'b0; valid_mul = 1'b0;
    @(negedge clk); rst = 1'b0;
    for (int r = 0; r < 5; r++) begin
      step(1, 0, 3'(r), 3'(r), 3'(r), 1, 0, 0, rdy);
      chk($sformatf("pre%0d.Pw", r), 32'(Pw), 32'(8 + r));
      $display("pre-reset alloc %0d: Pw=%0d", r, Pw);
    end
    @(negedge clk);
    valid_add = 1'b0;
    rst = 1'b1;
    #1;
    chk_out("async_rst", 1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 4'd0, 4'd0);
    chk("async_rst.ready", 32'(rename_ready), 32'd1);
    $display("async reset: out_add=%0b Pw=%0d ready=%0b", out_add, Pw, rename_ready);
    @(negedge clk); rst = 1'b0;

    // Eight back-to-back allocations exhaust the list; commit during empty
    for (int i = 0; i < 8; i++) begin
      step(1, 0, 3'(i), 3'(i), 3'(i), 1, 0, 0, rdy);
      chk($sformatf("b2b%0d.ready", i), 32'(rdy), 32'd1);
      chk_out($sformatf("b2b%0d", i), 1'b1, 1'b0, 1'b1, 4'(i), 4'(i), 4'(8 + i), 4'(i));
      $display("b2b %0d: Pa=%0d Pw=%0d Pw_old=%0d", i, Pa, Pw, Pw_old);
    end
    step(1, 0, 0, 1, 2, 1, 1, 3, rdy);
    chk("empty.ready", 32'(rdy), 32'd0);
    chk_out("empty", 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0);
    $display("empty+commit: ready=%0b", rdy);
    step(1, 0, 0, 1, 2, 1, 0, 0, rdy);
    chk("resume.ready", 32'(rdy), 32'd1);
    chk_out("resume", 1'b1, 1'b0, 1'b1, 4'd8, 4'd9, 4'd3, 4'd10);
    $display("resume: Pw=%0d", Pw);

    // Mixed push/pop against a queue model; both pointers wrap
    for (int i = 0; i < 8; i++) rat_m[i] = 4'(8 + i);
    rat_m[2] = 4'd3;
    for (int c = 0; c < 20; c++) begin
      logic iv, vm, cv, exp_rdy, acc;
      logic [2:0] ra_c, rb_c, rw_c;
      logic [3:0] cp, e_pa, e_pb, e_pw, e_pwo;
      iv = (c % 4) != 3;
      vm = iv && ((c % 2) == 1);
      cv = ((c % 3) != 1) && (fl_q.size() < 8);
      ra_c = 3'(c % 8); rb_c = 3'((c + 3) % 8); rw_c = 3'((c * 3) % 8);
      cp = 4'((c * 5) % 16);
      exp_rdy = fl_q.size() != 0;
      acc = iv && exp_rdy;
      e_pa = 0; e_pb = 0; e_pw = 0; e_pwo = 0;
      if (acc) begin
        e_pa = rat_m[ra_c]; e_pb = rat_m[rb_c]; e_pwo = rat_m[rw_c];
        e_pw = fl_q.pop_front();
        rat_m[rw_c] = e_pw;
      end
      if (cv) fl_q.push_back(cp);
      step(iv && !vm, vm, ra_c, rb_c, rw_c, 1, cv, cp, rdy);
      chk($sformatf("mix%0d.ready", c), 32'(rdy), 32'(exp_rdy));
      chk_out($sformatf("mix%0d", c), acc && !vm, acc && vm, acc, e_pa, e_pb, e_pw, e_pwo);
      $display("mix %0d: ready=%0b add=%0b mul=%0b Pw=%0d fl_size=%0d",
               c, rdy, out_add, out_mul, Pw, fl_q.size());
    end

    @(negedge clk);
    valid_add = 1'b0; valid_mul = 1'b0; commit_valid = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
